pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central sequencer for the five-stage RV32I pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

- Generates per-stage enable, flush and bubble controls from three event sources:
  - load-use hazards;
  - taken branches and jumps;
  - a multi-cycle data-memory handshake, with a timeout.
- Keeps saturating stall and flush event counters for performance monitoring.
- Sits beside the pipeline registers and drives their load/clear inputs. MEM/WB receives a bubble, meaning its write-enable is forced low, whenever the pipe is frozen.

## Interface
Parameters:
- DMEM_TIMEOUT, 255: maximum consecutive stalled cycles waiting on dmem_ready before the access is abandoned. Legal range is 2..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1_addr  in  5  rs1 of the instruction in ID.
- id_rs2_addr  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ex_rd_addr  in  5  rd of the instruction in EX.
- ex_reg_write  in  1  the EX instruction writes rd.
- ex_result_src  in  2  result source of the EX instruction; 2'b01 means memory load.
- ex_branch_taken  in  1  the EX instruction redirects the PC.
- mem_mem_access  in  1  the MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory request, held until completion or timeout.
- dmem_err  out  1  one-cycle pulse: the access was abandoned on timeout.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX clear.
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  MEM/WB loads a bubble (reg_write=0).
- stall_cycles  out  32  saturating count of cycles with pc_en=0.
- flush_count  out  32  saturating count of redirect flushes.

## Operation
State machine has two states: RUN and DMEM_WAIT. A 16-bit wait counter, wait_cnt, counts stalled cycles.

Internal events, evaluated combinationally each cycle:
- load_use = ex_reg_write & (ex_result_src==2'b01) & (ex_rd_addr!=0) & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)).
- dmem_stall = mem_mem_access & !dmem_ready & !timeout.
- timeout = (state==DMEM_WAIT) & (wait_cnt==DMEM_TIMEOUT-1) & !dmem_ready.

Priority, highest first:
1. **dmem_stall (freeze):**
   - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
   - mem_wb_bubble is 1.
   - Both flushes are 0. A pending branch or load-use is held and re-evaluated next cycle.
2. **ex_branch_taken (redirect):**
   - All enables are 1.
   - if_id_flush and id_ex_flush are 1.
   - flush_count increments.
   - A simultaneous load_use is ignored.
3. **load_use:**
   - pc_en and if_id_en are 0.
   - id_ex_en is 1 and id_ex_flush is 1, which inserts a bubble.
   - ex_mem_en is 1 and mem_wb_bubble is 0.
4. **Otherwise:** all enables are 1, flushes are 0 and mem_wb_bubble is 0.

dmem_req = mem_mem_access, in either state.

FSM transitions:
- RUN → DMEM_WAIT when dmem_stall. wait_cnt is set to 1.
- DMEM_WAIT with dmem_ready → RUN. The pipe advances this cycle and wait_cnt is set to 0.
- DMEM_WAIT with dmem_stall → stay in DMEM_WAIT. wait_cnt increments.
- DMEM_WAIT with timeout → RUN, and:
  - dmem_err=1 this cycle;
  - the pipe advances with mem_wb_bubble=1, so the access result is dropped;
  - wait_cnt is set to 0.

Counters:
- stall_cycles increments on each cycle with pc_en=0 and rst=0.
- Both counters saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- All control outputs are Mealy, i.e. combinational from state and current inputs. Stall and flush take effect at the same rising edge as the triggering condition; there is no added latency.
- A zero-wait access (dmem_ready with mem_mem_access in RUN) causes no stall and no state change.
- Load-use costs exactly 1 bubble cycle. On the next cycle the load is in MEM, so load_use is false.
- An access with N wait cycles (N < DMEM_TIMEOUT) freezes the pipe for N cycles.
- A timeout freezes for DMEM_TIMEOUT-1 cycles. On the next, DMEM_TIMEOUT-th stalled cycle the error pulse fires and the pipe advances.
- Reset values, applied while rst=1 regardless of other inputs:
  - state RUN and wait_cnt 0;
  - counters 0;
  - dmem_req 0 and dmem_err 0;
  - all enables 0;
  - if_id_flush 1, id_ex_flush 1, mem_wb_bubble 1.
- Reset during DMEM_WAIT abandons the access: dmem_req drops in the same cycle and dmem_err is not pulsed.

## Test plan
- **Load-use:** EX lw x5 (reg_write=1, src=01, rd=5), ID uses rs1=5 → 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle all enables are 1 and stall_cycles=1. Repeat with rd=0 → no stall.
- **Branch vs load-use:** ex_branch_taken=1 with load_use=1 → if_id_flush=1, id_ex_flush=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- **Multi-cycle access:** mem_mem_access=1 with dmem_ready low for 3 cycles, then high → 3 frozen cycles with mem_wb_bubble=1 and dmem_req=1 throughout. Cycle 4 advances and stall_cycles=3.
- **Timeout:** DMEM_TIMEOUT=4, dmem_ready held 0 → 3 frozen cycles, then one cycle with dmem_err=1, all enables 1 and mem_wb_bubble=1. The FSM returns to RUN.
- **Branch during freeze:** ex_branch_taken=1 during a dmem stall → no flush while frozen. The flush fires on the cycle dmem_ready=1.
- **Reset mid-wait:** assert rst in DMEM_WAIT → dmem_req=0, counters=0, FSM in RUN. After release with mem_mem_access=0, all enables are 1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a five-stage RV32I pipeline: drives PC and pipeline-register
// enables/flushes from load-use, redirect and multi-cycle data-memory events.
module pipeline_hazard_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_write,
    input  logic [1:0]  ex_result_src,
    input  logic        ex_branch_taken,
    input  logic        mem_mem_access,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_err,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        mem_wb_bubble,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {
        RUN,
        DMEM_WAIT
    } state_t;

    localparam logic [15:0] LAST_WAIT = 16'(DMEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] wait_cnt, wait_cnt_next;
    logic        rs1_hit, rs2_hit;
    logic        load_use, timeout, dmem_stall, redirect;

    always_comb begin
        rs1_hit    = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
        rs2_hit    = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
        load_use   = ex_reg_write && (ex_result_src == 2'b01) && (ex_rd_addr != 5'd0)
                     && (rs1_hit || rs2_hit);
        timeout    = (state == DMEM_WAIT) && (wait_cnt == LAST_WAIT) && !dmem_ready;
        dmem_stall = mem_mem_access && !dmem_ready && !timeout;
        redirect   = !rst && !dmem_stall && ex_branch_taken;
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        dmem_req      = mem_mem_access;
        dmem_err      = timeout;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;

        if (dmem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end

        // An abandoned access still advances the pipe but must not write back.
        if (timeout) begin
            mem_wb_bubble = 1'b1;
        end

        unique case (state)
            RUN: begin
                if (dmem_stall) begin
                    state_next    = DMEM_WAIT;
                    wait_cnt_next = 16'd1;
                end
            end
            DMEM_WAIT: begin
                if (dmem_stall) begin
                    wait_cnt_next = wait_cnt + 16'd1;
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        if (rst) begin
            state_next    = RUN;
            wait_cnt_next = '0;
            dmem_req      = 1'b0;
            dmem_err      = 1'b0;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// expected responses from a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_reg_write;
    logic [1:0]  ex_result_src;
    logic        ex_branch_taken, mem_mem_access, dmem_ready;
    logic        dmem_req, dmem_err, pc_en, if_id_en, if_id_flush;
    logic        id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
    logic [31:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DMEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_result_src(ex_result_src), .ex_branch_taken(ex_branch_taken),
        .mem_mem_access(mem_mem_access), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .dmem_err(dmem_err), .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    int unsigned frozen_run = 0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    // ctl order: req err pc ifid_en ifid_fl idex_en idex_fl exmem bubble
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic [1:0] src,
                        input logic br, input logic mem, input logic rdy);
        exp_t e;
        logic lu, to, frz;
        logic [8:0] c;
        @(posedge clk);
        #1;
        rst = r; id_rs1_addr = rs1; id_uses_rs1 = u1; id_rs2_addr = rs2; id_uses_rs2 = u2;
        ex_rd_addr = rd; ex_reg_write = rw; ex_result_src = src;
        ex_branch_taken = br; mem_mem_access = mem; dmem_ready = rdy;

        e.tag = tag;
        e.sc  = m_sc;
        e.fc  = m_fc;
        if (r) begin
            c = 9'b0_0_0_0_1_0_1_0_1;
            frozen_run = 0;
            m_sc = '0;
            m_fc = '0;
        end else begin
            lu  = rw && src == 2'b01 && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            to  = (frozen_run == TMO - 1) && !rdy;
            frz = mem && !rdy && !to;
            if (frz)
                c = 9'b0_0_0_0_0_0_0_0_1;
            else if (br)
                c = 9'b0_0_1_1_1_1_1_1_0;
            else if (lu)
                c = 9'b0_0_0_0_0_1_1_1_0;
            else
                c = 9'b0_0_1_1_0_1_0_1_0;
            c[8] = mem;
            c[7] = to;
            if (to) c[0] = 1'b1;
            if (!c[6] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (!frz && br && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            frozen_run = frz ? frozen_run + 1 : 0;
        end
        e.ctl = c;
        sbq.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                cur = sbq.pop_front();
                total++;
                if ({dmem_req, dmem_err, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                     ex_mem_en, mem_wb_bubble} !== cur.ctl) begin
                    bad++;
                    $display("FAIL %s ctl: got %b expected %b", cur.tag,
                             {dmem_req, dmem_err, pc_en, if_id_en, if_id_flush, id_ex_en,
                              id_ex_flush, ex_mem_en, mem_wb_bubble}, cur.ctl);
                end
                total++;
                if (stall_cycles !== cur.sc) begin
                    bad++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", cur.tag, stall_cycles, cur.sc);
                end
                total++;
                if (flush_count !== cur.fc) begin
                    bad++;
                    $display("FAIL %s flush_count: got %0d expected %0d", cur.tag, flush_count, cur.fc);
                end
            end
        end
    end

    initial begin
        logic       r, u1, u2, rw, br, mem, rdy;
        logic [4:0] rs1, rs2, rd;
        logic [1:0] src;

        rst = 1'b1;
        id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd_addr = '0; ex_reg_write = 0; ex_result_src = '0;
        ex_branch_taken = 0; mem_mem_access = 0; dmem_ready = 0;
        repeat (2) @(posedge clk);

        step("reset", 1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 2'b01, 1, 1, 0);
        step("reset2", 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0);
        idle("idle");

        step("load_use", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b01, 0, 0, 0);
        step("lu_after", 0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0);
        step("lu_rs2", 0, 5'd1, 1, 5'd7, 1, 5'd7, 1, 2'b01, 0, 0, 0);
        step("lu_rd0", 0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 2'b01, 0, 0, 0);
        step("lu_alu", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b00, 0, 0, 0);
        step("br_lu", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b01, 1, 0, 0);
        idle("br_lu_after");

        step("zero_wait", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 1);
        repeat (3) step("mc_wait", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0);
        step("mc_done", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 1);
        idle("mc_after");

        repeat (TMO) step("timeout", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0);
        idle("to_after");

        repeat (2) step("br_frozen", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 1, 0);
        step("br_release", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 1, 1);
        idle("br_after");

        repeat (2) step("pre_rst_wait", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0);
        step("rst_mid_wait", 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0);
        idle("post_rst");
        idle("post_rst2");

        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1  = 1'($urandom);
            u2  = 1'($urandom);
            rw  = 1'($urandom);
            src = 2'($urandom);
            br  = ($urandom_range(0, 5) == 0);
            mem = (frozen_run > 0) ? ($urandom_range(0, 15) != 0) : 1'($urandom);
            rdy = ($urandom_range(0, 2) == 0);
            step("random", r, rs1, u1, rs2, u2, rd, rw, src, br, mem, rdy);
        end

        repeat (3) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
